// File: rtl/max11046_frame_capture.sv
// MAX11046 frame capture: snoops CS/RD/DB and queues complete NUM_CH-word frames as a word stream.
// Optional FRAME_TIMESTAMP_EN appends a frame-counter word (chan = NUM_CH) to each committed frame.
module max11046_frame_capture #(
   parameter int unsigned NUM_CH  = 8,
   parameter int unsigned FIFO_AW = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             cs_n,
   input  logic             rd_n,
   input  logic [15:0]      db,
   output logic [15:0]      m_data,
   output logic [3:0]       m_chan,
   output logic             m_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             err_short,
   output logic             err_long
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned PW    = FIFO_AW + 1;
`ifdef FRAME_TIMESTAMP_EN
   localparam int unsigned ROOM  = NUM_CH + 1;
`else
   localparam int unsigned ROOM  = NUM_CH;
   localparam logic [3:0]  LAST_CH = 4'(NUM_CH - 1);
`endif
   localparam logic [3:0]    NCH      = 4'(NUM_CH);
   localparam logic [PW-1:0] MAX_USED = PW'(DEPTH - ROOM);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DROP    = 2'd2;

   logic        cs_s1, cs_s2, cs_prev;
   logic        rd_s1, rd_s2, rd_prev;
   logic [15:0] db_s1, db_s2, db_q;
   logic [1:0]  settle;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_ptr, rd_nxt;
   logic [3:0]    cnt_q, cnt_d;
   logic          long_q, long_d;
   logic [CNT_W-1:0] fc_d, dc_d, dc_inc;
   logic          short_d, elong_d;
   logic          we;
   logic [20:0]   wdata;
   logic [PW-1:0] used;
   logic          armed, cs_fall, cs_rise, rd_rise, room_ok, pop, avail;

   logic [20:0] mem [DEPTH];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_prev <= 1'b1;
         rd_s1   <= 1'b1;
         rd_s2   <= 1'b1;
         rd_prev <= 1'b1;
         db_s1   <= '0;
         db_s2   <= '0;
         db_q    <= '0;
         settle  <= '0;
      end else begin
         cs_s1   <= cs_n;
         cs_s2   <= cs_s1;
         cs_prev <= cs_s2;
         rd_s1   <= rd_n;
         rd_s2   <= rd_s1;
         rd_prev <= rd_s2;
         db_s1   <= db;
         db_s2   <= db_s1;
         db_q    <= db_s2;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   // Falling edges are ignored until the reset-value 1s have flushed out of the synchronizer,
   // so a burst already in progress at reset release is never mistaken for a new one.
   assign armed   = (settle == 2'd3);
   assign cs_fall = armed & cs_prev & ~cs_s2;
   assign cs_rise = ~cs_prev & cs_s2;
   assign rd_rise = ~rd_prev & rd_s2 & ~cs_s2;

   assign used    = wr_q - rd_ptr;
   assign room_ok = (used <= MAX_USED);
   assign dc_inc  = (drop_cnt == {CNT_W{1'b1}}) ? drop_cnt : drop_cnt + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      cm_d    = cm_q;
      cnt_d   = cnt_q;
      long_d  = long_q;
      fc_d    = frame_cnt;
      dc_d    = drop_cnt;
      short_d = 1'b0;
      elong_d = 1'b0;
      we      = 1'b0;
      wdata   = '0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               cnt_d   = '0;
               long_d  = 1'b0;
               state_d = room_ok ? ST_CAPTURE : ST_DROP;
            end
         end
         ST_CAPTURE: begin
            if (rd_rise) begin
               if (cnt_q < NCH) begin
                  we    = 1'b1;
`ifdef FRAME_TIMESTAMP_EN
                  wdata = {1'b0, cnt_q, db_q};
`else
                  wdata = {(cnt_q == LAST_CH), cnt_q, db_q};
`endif
                  wr_d  = wr_q + PW'(1);
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  long_d = 1'b1;
               end
            end else if (cs_rise) begin
               state_d = ST_IDLE;
               if (long_q) begin
                  wr_d    = cm_q;
                  elong_d = 1'b1;
                  dc_d    = dc_inc;
               end else if (cnt_q == NCH) begin
`ifdef FRAME_TIMESTAMP_EN
                  we    = 1'b1;
                  wdata = {1'b1, NCH, 16'(frame_cnt)};
                  wr_d  = wr_q + PW'(1);
                  cm_d  = wr_q + PW'(1);
`else
                  cm_d  = wr_q;
`endif
                  fc_d  = frame_cnt + CNT_W'(1);
               end else if (cnt_q == 4'd0) begin
                  wr_d = cm_q;
               end else begin
                  wr_d    = cm_q;
                  short_d = 1'b1;
                  dc_d    = dc_inc;
               end
            end
         end
         ST_DROP: begin
            if (cs_rise) begin
               dc_d    = dc_inc;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_q      <= '0;
         cm_q      <= '0;
         cnt_q     <= '0;
         long_q    <= 1'b0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         cm_q      <= cm_d;
         cnt_q     <= cnt_d;
         long_q    <= long_d;
         frame_cnt <= fc_d;
         drop_cnt  <= dc_d;
         err_short <= short_d;
         err_long  <= elong_d;
      end
   end

   always_ff @(posedge clock) begin
      if (we) mem[wr_q[FIFO_AW-1:0]] <= wdata;
   end

   // rd_ptr addresses the word shown on the output; it only moves on a pop, so the
   // output register reloads the same unchanged entry while the consumer stalls.
   assign pop = m_valid & m_ready;

   always_comb begin
      rd_nxt = rd_ptr;
      if (pop) rd_nxt = rd_ptr + PW'(1);
   end

   assign avail = (cm_q != rd_nxt);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_chan  <= '0;
         m_data  <= '0;
      end else begin
         rd_ptr  <= rd_nxt;
         m_valid <= avail;
         if (avail) {m_last, m_chan, m_data} <= mem[rd_nxt[FIFO_AW-1:0]];
      end
   end

endmodule

// File: doc/max11046_frame_capture.md
Name: max11046_frame_capture

Overview:
- Downstream stage of the MAX11046 read controller. Snoops the ADC parallel bus (DB) and the controller's CS/RD strobes, all asynchronous to the FPGA clock.
- Assembles each CS-low read burst into one frame of NUM_CH 16-bit channel words.
- Stores only complete frames in an internal word FIFO. Presents them to the force-processing / host-link logic as a valid/ready word stream tagged with channel index and end-of-frame.

Parameters:
- NUM_CH, 8: channel reads per frame (1..8).
- FIFO_AW, 5: FIFO address width; depth = 2^FIFO_AW words. Must be ≥ NUM_CH+1.
- CNT_W, 16: width of the frame and drop counters.

Ports:
- clock, in, 1: FPGA clock (OSCH, 133 MHz).
- rst_n, in, 1: asynchronous active-low reset.
- cs_n, in, 1: ADC chip select as driven by the read controller (async).
- rd_n, in, 1: ADC read strobe as driven by the read controller (async).
- db, in, 16: ADC data bus DB[15:0] (async).
- m_data, out, 16: stream data word.
- m_chan, out, 4: channel index of m_data (0..NUM_CH-1; NUM_CH marks the timestamp word).
- m_last, out, 1: last word of frame.
- m_valid, out, 1: word available.
- m_ready, in, 1: consumer accepts word.
- frame_cnt, out, CNT_W: committed frames, wraps.
- drop_cnt, out, CNT_W: dropped frames (FIFO full or malformed), saturates at all-ones.
- err_short, out, 1: 1-cycle pulse, burst ended with fewer than NUM_CH reads.
- err_long, out, 1: 1-cycle pulse, burst contained more than NUM_CH reads.

Behaviour:
- Reset (async, rst_n=0):
  - m_valid, m_last, err_short and err_long = 0.
  - m_data, m_chan, frame_cnt and drop_cnt = 0.
  - FIFO empty; FSM in IDLE; synchronizers load 1 for cs_n/rd_n and 0 for db.
- Input synchronization:
  - cs_n and rd_n pass through 2-FF synchronizers.
  - db passes through an equal-depth 2-stage register pipeline, so the data word stays aligned with the synchronized strobes.
- Edge detection:
  - rd rise = synced rd_n goes 0 then 1 while synced cs_n = 0.
  - Captured word = db pipeline output from the cycle before the rise, i.e. the last sample taken while RD was low.
- FSM states: IDLE, CAPTURE, DROP.
  - IDLE → on synced cs_n falling edge:
    - go to CAPTURE if FIFO free words ≥ W, where W = NUM_CH, or NUM_CH+1 with the optional feature;
    - otherwise go to DROP.
  - CAPTURE:
    - Each rd rise writes the word at the tentative write pointer with chan = rd count and last = (rd count == NUM_CH-1, or feature word pending), then increments the tentative pointer.
    - Reads beyond NUM_CH are not written; they set the long flag.
  - CAPTURE → IDLE on synced cs_n rising edge:
    - exactly NUM_CH reads, no long flag: copy tentative pointer to commit pointer and increment frame_cnt;
    - 0 reads: rewind, no error, no count;
    - 1..NUM_CH-1 reads: rewind tentative pointer to commit pointer, pulse err_short, increment drop_cnt;
    - long flag set: rewind, pulse err_long, increment drop_cnt.
  - DROP: ignores rd; on cs_n rising edge, increment drop_cnt and return to IDLE.
- FIFO:
  - Stores {last, chan, data}. Only committed words are visible to the read side.
  - m_valid = commit pointer ≠ read pointer. The output register is first-word-fall-through; pop on m_valid & m_ready.
  - m_data, m_chan and m_last hold stable while m_valid=1 and m_ready=0.
  - Free words = depth − (tentative − read), computed mod 2^(FIFO_AW+1).
  - Same-cycle push and pop are both legal; a pop during CAPTURE can only add space.
- Latency: first word of a frame reaches m_valid no earlier than 2 clocks after the synced cs_n rise that commits it; never before the commit.
- Pointer wrap: pointers are FIFO_AW+1 bits; full/empty are distinguished by the MSB.
- Reset asserted mid-burst: the frame in progress is lost; after release the FSM restarts in IDLE and waits for a fresh cs_n falling edge. A burst already in progress at release is not captured (no falling edge is seen).

Optional Feature:
- Macro: FRAME_TIMESTAMP_EN.
- Defined:
  - at commit, one extra word is written after channel NUM_CH-1, with data = frame_cnt[15:0] value before increment, chan = NUM_CH, last = 1;
  - channel NUM_CH-1 then has last = 0;
  - the room check uses NUM_CH+1.
- Undefined: no extra word; channel NUM_CH-1 carries last = 1; the room check uses NUM_CH.

Test Plan:
- Capture order:
  - Stimulus: burst of 8 reads, db = 0x1000+i, m_ready=1.
  - Response: stream words 0x1000..0x1007, chan 0..7, m_last only on chan 7, frame_cnt=1.
- Short burst:
  - Stimulus: 5 reads then cs_n high.
  - Response: no m_valid, err_short pulses once, drop_cnt=1, FIFO pointers unchanged.
- Long burst:
  - Stimulus: 9 reads.
  - Response: err_long pulse, no output, drop_cnt=1; next 8-read burst is output intact.
- Backpressure / full:
  - Stimulus: FIFO_AW=4, m_ready=0, 3 bursts of 8 reads.
  - Response: frames 1–2 stored, frame 3 goes to DROP, drop_cnt=1; releasing m_ready outputs exactly 16 words in order.
- Async reset mid-burst:
  - Stimulus: rst_n low after 3 reads, release while cs_n still low, finish burst, then a full burst.
  - Response: no output from the interrupted burst; the full burst is output; frame_cnt=1.
- FRAME_TIMESTAMP_EN:
  - Stimulus: two good bursts.
  - Response: 9 words per frame; word 9 has chan=8, m_last=1, data 0x0000 then 0x0001.
